// File: rtl/data_sram_responder.sv
// Data-SRAM responder: accepts load/store requests over req/addr_ok and answers
// each one in order on data_ok after a fixed latency, backed by a word array.
module data_sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int RESP_LAT    = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam int         PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(RESP_LAT - 1);
    localparam logic [2:0] Q_FULL   = 3'(QUEUE_DEPTH);

    logic [31:0]           mem_r [WORDS];
    logic [2:0]            count_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic                  entry_rd_r   [QUEUE_DEPTH];
    logic [31:0]           entry_data_r [QUEUE_DEPTH];
    logic [3:0]            entry_cnt_r  [QUEUE_DEPTH];
    logic                  push_s;
    logic                  pop_s;
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic                  unused_s;

    // Circular pointer advance, wrapping modulo the queue depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(QUEUE_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign word_idx_s = data_sram_addr[DEPTH_LOG2+1:2];
    assign unused_s   = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:DEPTH_LOG2+2]};

    // Acceptance depends only on the registered occupancy, never on req or a same-cycle pop.
    always_comb begin
        data_sram_addr_ok = 1'b0;
        if (!reset && (count_r < Q_FULL)) begin
            data_sram_addr_ok = 1'b1;
        end else begin
            data_sram_addr_ok = 1'b0;
        end
    end

    // Head response: stores answer with zero data.
    always_comb begin
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        if (!reset && (count_r != 3'd0) && (entry_cnt_r[head_r] == 4'd0)) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = entry_rd_r[head_r] ? entry_data_r[head_r] : 32'h0000_0000;
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0000_0000;
        end
    end

    // Handshake events for this edge.
    always_comb begin
        push_s = data_sram_req & data_sram_addr_ok;
        pop_s  = data_sram_data_ok;
    end

    // Backing array byte writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_s && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue: countdown per entry, push at tail, retire at head.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 3'd0;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_rd_r[i]   <= 1'b0;
                entry_data_r[i] <= 32'h0000_0000;
                entry_cnt_r[i]  <= 4'd0;
            end
        end else begin
            // Free slots count down too; a push always reloads its slot.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (entry_cnt_r[i] != 4'd0) begin
                    entry_cnt_r[i] <= entry_cnt_r[i] - 4'd1;
                end
            end
            if (push_s) begin
                entry_cnt_r[tail_r]  <= CNT_INIT;
                entry_rd_r[tail_r]   <= ~data_sram_wr;
                entry_data_r[tail_r] <= data_sram_wr ? 32'h0000_0000 : mem_r[word_idx_s];
                tail_r               <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios plus a
// randomized run against a queue/array reference model.
module tb_data_sram_responder;

    localparam int LAT_A = 2;
    localparam int QD_A  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_wr, b_req, b_wr;
    logic [1:0]  a_size, b_size;
    logic [3:0]  a_wstrb, b_wstrb;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_addr_ok, a_data_ok, b_addr_ok, b_data_ok;
    logic [31:0] a_rdata, b_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] pre_d [3];

    typedef struct {
        int          due;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    always #5 clk = ~clk;

    data_sram_responder #(.DEPTH_LOG2(10), .RESP_LAT(LAT_A), .QUEUE_DEPTH(QD_A)) dut_a (
        .clk(clk), .reset(reset),
        .data_sram_req(a_req), .data_sram_wr(a_wr), .data_sram_size(a_size),
        .data_sram_wstrb(a_wstrb), .data_sram_addr(a_addr), .data_sram_wdata(a_wdata),
        .data_sram_addr_ok(a_addr_ok), .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_rdata)
    );

    data_sram_responder #(.DEPTH_LOG2(10), .RESP_LAT(1), .QUEUE_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .data_sram_req(b_req), .data_sram_wr(b_wr), .data_sram_size(b_size),
        .data_sram_wstrb(b_wstrb), .data_sram_addr(b_addr), .data_sram_wdata(b_wdata),
        .data_sram_addr_ok(b_addr_ok), .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        a_req   = req;
        a_wr    = wr;
        a_addr  = addr;
        a_wdata = wdata;
        a_wstrb = strb;
        a_size  = (strb == 4'hF || !wr) ? 2'd2 : 2'd0;
    endtask

    task automatic b_drive(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        b_req   = req;
        b_wr    = wr;
        b_addr  = addr;
        b_wdata = wdata;
        b_wstrb = strb;
        b_size  = 2'd2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (a_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_aok: got %b exp 0", a_addr_ok); end
        n_checks++; if (a_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_dok: got %b exp 0", a_data_ok); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", a_rdata); end
        n_checks++; if (b_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_b_aok: got %b exp 0", b_addr_ok); end
        reset = 1'b0;
        #1;
        n_checks++; if (a_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_rel_aok: got %b exp 1", a_addr_ok); end
        n_checks++; if (b_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_rel_b_aok: got %b exp 1", b_addr_ok); end
    endtask

    task automatic test_store_load();
        a_drive(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        n_checks++; if (a_addr_ok !== 1'b1) begin n_fail++; $display("FAIL sl_st_aok: got %b exp 1", a_addr_ok); end
        tick();
        a_drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        n_checks++; if ({a_addr_ok, a_data_ok} !== 2'b10) begin n_fail++; $display("FAIL sl_ld_aok_dok: got %b exp 10", {a_addr_ok, a_data_ok}); end
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if (a_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sl_full_aok: got %b exp 0", a_addr_ok); end
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL sl_st_resp: got %b/%h exp 1/0", a_data_ok, a_rdata); end
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL sl_ld_resp: got %b/%h exp 1/12345678", a_data_ok, a_rdata); end
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL sl_empty: got %b/%h exp 0/0", a_data_ok, a_rdata); end
        a_drive(1'b1, 1'b1, 32'h41, 32'h0000_AB00, 4'b0010);
        tick();
        a_drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL sl_pst_resp: got %b/%h exp 1/0", a_data_ok, a_rdata); end
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, 32'h1234_AB78}) begin n_fail++; $display("FAIL sl_merge: got %b/%h exp 1/1234ab78", a_data_ok, a_rdata); end
        tick();
    endtask

    task automatic test_full_backpressure();
        for (int i = 0; i < 3; i++) begin
            pre_d[i] = $urandom;
            a_drive(1'b1, 1'b1, 32'(i * 4), pre_d[i], 4'hF);
            tick();
            a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            tick();
            tick();
        end
        a_drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if (a_addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_aok0: got %b exp 1", a_addr_ok); end
        tick();
        a_drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        n_checks++; if ({a_addr_ok, a_data_ok} !== 2'b10) begin n_fail++; $display("FAIL bp_aok1: got %b exp 10", {a_addr_ok, a_data_ok}); end
        tick();
        a_drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        n_checks++; if (a_addr_ok !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b exp 0", a_addr_ok); end
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, pre_d[0]}) begin n_fail++; $display("FAIL bp_r0: got %b/%h exp 1/%h", a_data_ok, a_rdata, pre_d[0]); end
        tick();
        n_checks++; if (a_addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b exp 1", a_addr_ok); end
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, pre_d[1]}) begin n_fail++; $display("FAIL bp_r1: got %b/%h exp 1/%h", a_data_ok, a_rdata, pre_d[1]); end
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if (a_data_ok !== 1'b0) begin n_fail++; $display("FAIL bp_gap: got %b exp 0", a_data_ok); end
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, pre_d[2]}) begin n_fail++; $display("FAIL bp_r2: got %b/%h exp 1/%h", a_data_ok, a_rdata, pre_d[2]); end
        tick();
        n_checks++; if (a_data_ok !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b exp 0", a_data_ok); end
    endtask

    task automatic test_reset_mid();
        a_drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        a_drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        #1;
        n_checks++; if ({a_addr_ok, a_data_ok} !== 2'b00) begin n_fail++; $display("FAIL rm_during: got %b exp 00", {a_addr_ok, a_data_ok}); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h exp 0", a_rdata); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if ({a_addr_ok, a_data_ok} !== 2'b10) begin n_fail++; $display("FAIL rm_after: got %b exp 10", {a_addr_ok, a_data_ok}); end
        a_drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if (a_data_ok !== 1'b0) begin n_fail++; $display("FAIL rm_nostale: got %b exp 0", a_data_ok); end
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, pre_d[0]}) begin n_fail++; $display("FAIL rm_keep: got %b/%h exp 1/%h", a_data_ok, a_rdata, pre_d[0]); end
        tick();
    endtask

    task automatic test_alias();
        a_drive(1'b1, 1'b1, 32'h1040, 32'h55AA_55AA, 4'hF);
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        a_drive(1'b1, 1'b0, 32'h0040, 32'h0, 4'h0);
        tick();
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        n_checks++; if ({a_data_ok, a_rdata} !== {1'b1, 32'h55AA_55AA}) begin n_fail++; $display("FAIL alias: got %b/%h exp 1/55aa55aa", a_data_ok, a_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        b_drive(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 4'hF);
        n_checks++; if (b_addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_aok0: got %b exp 1", b_addr_ok); end
        tick();
        b_drive(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        n_checks++; if (b_addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_aok1: got %b exp 1", b_addr_ok); end
        n_checks++; if ({b_data_ok, b_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL b2b_st: got %b/%h exp 1/0", b_data_ok, b_rdata); end
        tick();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++; if ({b_data_ok, b_rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL b2b_ld: got %b/%h exp 1/cafef00d", b_data_ok, b_rdata); end
        tick();
        n_checks++; if (b_data_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b exp 0", b_data_ok); end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] ref_mem [1024];
        bit          ref_valid [1024];
        bit          e_aok, e_dok, rq, wr;
        logic [31:0] e_rd, addr, wd;
        logic [3:0]  strb;
        int          ridx;
        for (int k = 0; k < 1024; k++) ref_valid[k] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            e_aok = (q.size() < QD_A);
            e_dok = (q.size() > 0) && (q[0].due <= cyc);
            e_rd  = (e_dok && q[0].is_read) ? q[0].data : 32'h0;
            n_checks++; if (a_addr_ok !== e_aok) begin n_fail++; $display("FAIL rnd_aok cyc %0d: got %b exp %b", cyc, a_addr_ok, e_aok); end
            n_checks++; if (a_data_ok !== e_dok) begin n_fail++; $display("FAIL rnd_dok cyc %0d: got %b exp %b", cyc, a_data_ok, e_dok); end
            n_checks++; if (a_rdata !== e_rd) begin n_fail++; $display("FAIL rnd_rdata cyc %0d: got %h exp %h", cyc, a_rdata, e_rd); end
            rq   = (cyc < 390) && ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            ridx = (addr >> 2) % 1024;
            wr   = $urandom_range(0, 1);
            strb = 4'($urandom_range(1, 15));
            wd   = $urandom;
            if (!ref_valid[ridx]) begin
                wr   = 1'b1;
                strb = 4'hF;
            end
            a_drive(rq, wr, addr, wd, strb);
            if (e_dok) q.pop_front();
            if (rq && e_aok) begin
                e.due = cyc + LAT_A;
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) ref_mem[ridx][8*b +: 8] = wd[8*b +: 8];
                    end
                    ref_valid[ridx] = 1'b1;
                    e.is_read = 1'b0;
                    e.data    = 32'h0;
                end else begin
                    e.is_read = 1'b1;
                    e.data    = ref_mem[ridx];
                end
                q.push_back(e);
            end
            tick();
        end
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        a_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        b_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        test_reset();
        test_store_load();
        test_full_backpressure();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
